// File: rtl/newhope_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : newhope_pkg
//  Description : Constants and the decoder state type shared by the NewHope
//                message decoder slice.
//  Revision    : 1.0  initial release
// ============================================================================
package newhope_pkg;

  localparam int unsigned NEWHOPE_Q         = 12289;
  localparam int unsigned NEWHOPE_HALF_Q    = 6144;
  localparam int unsigned NEWHOPE_N         = 512;
  localparam int unsigned NEWHOPE_MSG_BYTES = 32;

  // 16-bit views of the constants used in the datapath arithmetic
  localparam logic [15:0] NEWHOPE_Q16      = 16'd12289;
  localparam logic [15:0] NEWHOPE_HALF_Q16 = 16'd6144;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH_LO = 3'd1,
    ST_FETCH_HI = 3'd2,
    ST_ACCUM    = 3'd3,
    ST_WRITE    = 3'd4,
    ST_DONE     = 3'd5
  } dec_state_t;

  // Single conditional subtraction of Q: maps [0, 2Q-1] onto [0, Q-1].
  function automatic logic [15:0] nh_csub(input logic [15:0] x);
    return (x >= NEWHOPE_Q16) ? (x - NEWHOPE_Q16) : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msg_decoder_pl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : msg_decoder_pl_if
//  Description : Control handshake, polynomial RAM read port and message RAM
//                write port of the NewHope message decoder.
//                slave  = decoder side, master = controller / RAM side.
//  Revision    : 1.0  initial release
// ============================================================================
interface msg_decoder_pl_if;

  logic        start;
  logic        done;
  logic [8:0]  poly_addrb;
  logic [15:0] poly_dob;
  logic        msg_we;
  logic [2:0]  msg_addr;
  // Bit 31 is the MSB of the lowest-addressed message byte of the word,
  // so the word reads as four bytes in big-endian order.
  logic [31:0] msg_di;

  modport slave (
    input  start,
    input  poly_dob,
    output done,
    output poly_addrb,
    output msg_we,
    output msg_addr,
    output msg_di
  );

  modport master (
    output start,
    output poly_dob,
    input  done,
    input  poly_addrb,
    input  msg_we,
    input  msg_addr,
    input  msg_di
  );

endinterface
`default_nettype wire

// File: rtl/nh_flipabs.sv
`default_nettype none
// ============================================================================
//  Module      : nh_flipabs
//  Description : Combinational NewHope flipabs: y = | x - Q/2 |, with the
//                difference taken as a 16-bit two's-complement value.
//  Revision    : 1.0  initial release
// ============================================================================
module nh_flipabs
  import newhope_pkg::*;
(
  input  logic [15:0] x,
  output logic [15:0] y
);

  logic [15:0] r;

  // Centre the coefficient on Q/2 and fold negative results back to positive
  always_comb begin
    r = x - NEWHOPE_HALF_Q16;
    y = r[15] ? (16'd0 - r) : r;
  end

endmodule
`default_nettype wire

// File: rtl/msg_decoder_pl.sv
`default_nettype none
// ============================================================================
//  Module      : msg_decoder_pl
//  Description : Recovers the 32-byte NewHope message from a 512-coefficient
//                polynomial. Bit k is decided from coefficients k and k+256
//                with the flipabs threshold test and packed into eight
//                32-bit message words.
//                Optional macro MSG_DECODER_CSUB_EN: reduce each coefficient
//                modulo Q once before flipabs (input range [0, 2Q-1]).
//  Revision    : 1.0  initial release
// ============================================================================
module msg_decoder_pl
  import newhope_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  msg_decoder_pl_if.slave   bus
);

  dec_state_t  state;
  logic [7:0]  k;
  logic [15:0] lo;
  logic [31:0] word;

  logic [15:0] lo_fix;
  logic [15:0] hi_fix;
  logic [15:0] lo_abs;
  logic [15:0] hi_abs;
  logic [15:0] sum;
  logic [15:0] diff;
  logic        bit_val;
  logic [4:0]  bit_pos;

`ifdef MSG_DECODER_CSUB_EN
  assign lo_fix = nh_csub(lo);
  assign hi_fix = nh_csub(bus.poly_dob);
`else
  assign lo_fix = lo;
  assign hi_fix = bus.poly_dob;
`endif

  nh_flipabs u_flipabs_lo (
    .x (lo_fix),
    .y (lo_abs)
  );

  nh_flipabs u_flipabs_hi (
    .x (hi_fix),
    .y (hi_abs)
  );

  // Bit decision: 1 when the combined distance from Q/2 is below Q/2
  always_comb begin
    sum     = lo_abs + hi_abs;
    diff    = sum - NEWHOPE_HALF_Q16;
    bit_val = diff[15];
    // Message bit k is bit k[2:0] (LSB first) of byte k[4:3] within the word;
    // byte 0 occupies bits 31:24, so position = 31 - {k[4:3], ~k[2:0]}.
    bit_pos = {~k[4:3], k[2:0]};
  end

  // Sequencer: fetch the coefficient pair, accumulate one bit, flush words
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      k     <= 8'd0;
      lo    <= 16'd0;
      word  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state <= ST_FETCH_LO;
            k     <= 8'd0;
            word  <= 32'd0;
          end
        end
        ST_FETCH_LO: begin
          state <= ST_FETCH_HI;
        end
        ST_FETCH_HI: begin
          // RAM data for address k arrives this cycle
          lo    <= bus.poly_dob;
          state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          word[bit_pos] <= bit_val;
          if (k[4:0] == 5'd31) begin
            state <= ST_WRITE;
          end else begin
            k     <= k + 8'd1;
            state <= ST_FETCH_LO;
          end
        end
        ST_WRITE: begin
          if (k == 8'd255) begin
            state <= ST_DONE;
          end else begin
            k     <= k + 8'd1;
            state <= ST_FETCH_LO;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Port decode from the registered state and bit counter
  always_comb begin
    bus.poly_addrb = 9'd0;
    bus.msg_we     = 1'b0;
    bus.msg_addr   = 3'd0;
    bus.done       = 1'b0;
    case (state)
      ST_FETCH_LO: bus.poly_addrb = {1'b0, k};
      ST_FETCH_HI: bus.poly_addrb = {1'b1, k};
      ST_WRITE: begin
        bus.msg_we   = 1'b1;
        bus.msg_addr = k[7:5];
      end
      ST_DONE:     bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.msg_di = word;

endmodule
`default_nettype wire

// File: tb/tb_msg_decoder_pl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msg_decoder_pl
//  Description : Self-checking bench for msg_decoder_pl with a synchronous
//                polynomial RAM model and a table of directed messages.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_msg_decoder_pl;

  logic clk;
  logic rst;

  msg_decoder_pl_if bus ();

  msg_decoder_pl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read polynomial RAM
  logic [15:0] poly [0:511];
  always @(posedge clk) bus.poly_dob <= poly[bus.poly_addrb];

  int tests  = 0;
  int failed = 0;
  logic [31:0] got_words [0:7];

  typedef struct {
    string        name;
    logic [255:0] msg;     // byte 0 in bits 255:248
    logic [15:0]  lo1, hi1, lo0, hi0;
    logic [31:0]  exp_w0;  // hand-computed first word
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Fill the polynomial: bit k = bit (k%8) of byte k/8, carried in c[k], c[k+256]
  task automatic load_msg(input logic [255:0] m, input logic [15:0] lo1, input logic [15:0] hi1,
                          input logic [15:0] lo0, input logic [15:0] hi0);
    logic [7:0] b;
    for (int k = 0; k < 256; k++) begin
      b = m[255 - 8*(k/8) -: 8];
      if (b[k%8]) begin
        poly[k] = lo1; poly[k+256] = hi1;
      end else begin
        poly[k] = lo0; poly[k+256] = hi0;
      end
    end
  endtask

  task automatic fill_all(input logic [15:0] v);
    for (int i = 0; i < 512; i++) poly[i] = v;
  endtask

  // One full decode: start sampled at E0, then 900 cycles observed on negedges
  task automatic run_decode(input string tag, input int pulse_at);
    int  writes, done_cnt, done_cyc, first_w, last_w;
    bit  order_ok;
    writes = 0; done_cnt = 0; done_cyc = 0; first_w = 0; last_w = 0; order_ok = 1'b1;
    for (int i = 0; i < 8; i++) got_words[i] = 32'hDEAD_0000;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 900; c++) begin
      @(negedge clk);
      bus.start = (c == pulse_at);
      if (bus.msg_we) begin
        if (bus.msg_addr != 3'(writes)) order_ok = 1'b0;
        got_words[bus.msg_addr] = bus.msg_di;
        if (writes == 0) first_w = c;
        last_w = c;
        writes++;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
    end
    check($sformatf("%s write_count", tag), 32'(writes), 32'd8);
    check($sformatf("%s addr_order", tag), {31'd0, order_ok}, 32'd1);
    check($sformatf("%s first_write_cycle", tag), 32'(first_w), 32'd97);
    check($sformatf("%s last_write_cycle", tag), 32'(last_w), 32'd776);
    check($sformatf("%s done_cycle", tag), 32'(done_cyc), 32'd777);
    check($sformatf("%s done_count", tag), 32'(done_cnt), 32'd1);
  endtask

  task automatic check_words(input string tag, input logic [255:0] m);
    for (int w = 0; w < 8; w++)
      check($sformatf("%s word%0d", tag, w), got_words[w], m[255 - 32*w -: 32]);
  endtask

  initial begin
    int   we_cnt, done_cnt, addr_cnt;
    logic [31:0] csub_exp;

    vecs[0] = '{"encoded", 256'hA5001122334455667788_99AABBCCDDEEF0E1D2C3B4A596877869_5A4B3C2D1EFF,
                16'd6144, 16'd6144, 16'd0, 16'd0, 32'hA500_1122};
    vecs[1] = '{"all_zero", 256'h0, 16'd6144, 16'd6144, 16'd0, 16'd0, 32'h0000_0000};
    vecs[2] = '{"all_half", {256{1'b1}}, 16'd6144, 16'd6144, 16'd0, 16'd0, 32'hFFFF_FFFF};
    vecs[3] = '{"noisy", 256'hDEADBEEF_CAFEBABE_01234567_89ABCDEF_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0,
                16'd9144, 16'd3144, 16'd10788, 16'd10788, 32'hDEAD_BEEF};
    vecs[4] = '{"q_minus1", 256'h80017EFF_00000001_12345678_9ABCDEF0_FFFF0000_0000FFFF_55AA55AA_C0FFEE00,
                16'd6144, 16'd6144, 16'd12288, 16'd12288, 32'h8001_7EFF};

    rst = 1'b1;
    bus.start = 1'b0;
    fill_all(16'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset msg_we", {31'd0, bus.msg_we}, 32'd0);
    check("reset msg_addr", {29'd0, bus.msg_addr}, 32'd0);
    check("reset msg_di", bus.msg_di, 32'd0);
    check("reset poly_addrb", {23'd0, bus.poly_addrb}, 32'd0);
    rst = 1'b0;

    // Table of full-message vectors
    for (int v = 0; v < 5; v++) begin
      load_msg(vecs[v].msg, vecs[v].lo1, vecs[v].hi1, vecs[v].lo0, vecs[v].hi0);
      run_decode(vecs[v].name, 0);
      check_words(vecs[v].name, vecs[v].msg);
      check($sformatf("%s word0_const", vecs[v].name), got_words[0], vecs[v].exp_w0);
    end

    // Threshold: sum 6145 -> bit 0
    fill_all(16'd0);
    poly[0] = 16'd3072; poly[256] = 16'd3071;
    run_decode("thr_6145", 0);
    check("thr_6145 word0", got_words[0], 32'h0000_0000);

    // Threshold: sum 6143 -> bit 1 (LSB of byte 0)
    poly[256] = 16'd3073;
    run_decode("thr_6143", 0);
    check("thr_6143 word0", got_words[0], 32'h0100_0000);

    // Out-of-range coefficient Q/2 + Q
    fill_all(16'd0);
    poly[0] = 16'd18433; poly[256] = 16'd18433;
`ifdef MSG_DECODER_CSUB_EN
    csub_exp = 32'h0100_0000;
`else
    csub_exp = 32'h0000_0000;
`endif
    run_decode("csub", 0);
    check("csub word0", got_words[0], csub_exp);

    // start pulsed mid-run is ignored
    load_msg(vecs[3].msg, vecs[3].lo1, vecs[3].hi1, vecs[3].lo0, vecs[3].hi0);
    run_decode("mid_start", 50);
    check_words("mid_start", vecs[3].msg);

    // Reset at cycle 300 aborts the run
    load_msg(vecs[0].msg, vecs[0].lo1, vecs[0].hi1, vecs[0].lo0, vecs[0].hi0);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 300) rst = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort done", {31'd0, bus.done}, 32'd0);
    check("abort msg_we", {31'd0, bus.msg_we}, 32'd0);
    check("abort msg_addr", {29'd0, bus.msg_addr}, 32'd0);
    check("abort msg_di", bus.msg_di, 32'd0);
    check("abort poly_addrb", {23'd0, bus.poly_addrb}, 32'd0);
    we_cnt = 0; done_cnt = 0; addr_cnt = 0;
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      if (bus.msg_we) we_cnt++;
      if (bus.done) done_cnt++;
      if (bus.poly_addrb != 9'd0) addr_cnt++;
    end
    check("abort later_we", 32'(we_cnt), 32'd0);
    check("abort later_done", 32'(done_cnt), 32'd0);
    check("abort idle_addr", 32'(addr_cnt), 32'd0);

    // A fresh start after the abort completes normally
    run_decode("after_abort", 0);
    check_words("after_abort", vecs[0].msg);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
